// File: rtl/meas_bcd_streamer_if.sv
// Digit stream from meas_bcd_streamer to the display/readout logic.
// Uses a valid/ready handshake; the payload is the digit, its position,
// its field code and the LAST/OVF qualifiers.
interface meas_bcd_streamer_if;
  logic [3:0] DIGIT_OUT;
  logic [2:0] DIGIT_IDX;
  logic [2:0] FIELD;
  logic       DIGIT_VALID;
  logic       DIGIT_READY;
  logic       LAST;
  logic       OVF;

  modport master (
    output DIGIT_OUT, DIGIT_IDX, FIELD, DIGIT_VALID, LAST, OVF,
    input  DIGIT_READY
  );

  modport slave (
    input  DIGIT_OUT, DIGIT_IDX, FIELD, DIGIT_VALID, LAST, OVF,
    output DIGIT_READY
  );
endinterface

// File: rtl/meas_bcd_streamer.sv
// Output stage downstream of function_block. On START it snapshots the five
// measurement results, converts each to 8 BCD digits with a sequential
// double-dabble engine (32 cycles per field), and streams the digits,
// most significant first, over the valid/ready digit interface.
module meas_bcd_streamer (
  input  logic                       CLK,
  input  logic                       RSTB,
  input  logic                       START,
  input  logic [31:0]                max_vol,
  input  logic [31:0]                min_vol,
  input  logic [31:0]                mean_vol,
  input  logic [31:0]                Vp2p_vol_t,
  input  logic [23:0]                frequency,
  meas_bcd_streamer_if.master        dig,
  output logic                       BUSY,
  output logic                       DONE
);

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  localparam logic [31:0] BCD_MAX = 32'd99_999_999;

  state_t            state_q, state_d;
  logic [4:0][31:0]  snap_q, snap_d;
  logic [2:0]        field_q, field_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       bcd_q, bcd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [2:0]        idx_q, idx_d;

  logic [2:0]        field_nxt;
  logic [31:0]       nxt_val;
  logic [31:0]       bcd_adj;
  logic [3:0]        digit_raw;

  // Select the snapshot belonging to the field that follows the current one
  always_comb begin
    field_nxt = field_q + 3'd1;
    nxt_val   = snap_q[0];
    case (field_nxt)
      3'd1:    nxt_val = snap_q[1];
      3'd2:    nxt_val = snap_q[2];
      3'd3:    nxt_val = snap_q[3];
      3'd4:    nxt_val = snap_q[4];
      default: nxt_val = snap_q[0];
    endcase
  end

  // Add-3 correction for every BCD nibble that is 5 or more
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic: snapshot/load, conversion iterations and digit handshake
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    field_d = field_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          snap_d  = {{8'd0, frequency}, Vp2p_vol_t, mean_vol, min_vol, max_vol};
          field_d = 3'd0;
          shift_d = max_vol;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (max_vol > BCD_MAX);
          busy_d  = 1'b1;
          idx_d   = 3'd0;
          state_d = CONV;
        end
      end

      CONV: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          idx_d   = 3'd0;
          valid_d = 1'b1;
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (dig.DIGIT_READY) begin
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
          end else if (field_q != 3'd4) begin
            field_d = field_nxt;
            shift_d = nxt_val;
            bcd_d   = '0;
            cnt_d   = '0;
            ovf_d   = (nxt_val > BCD_MAX);
            idx_d   = 3'd0;
            valid_d = 1'b0;
            state_d = CONV;
          end else begin
            idx_d   = 3'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RSTB) begin
      state_q <= IDLE;
      snap_q  <= '0;
      field_q <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      field_q <= field_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  // Digit mux: ~idx*4 picks nibble 31-4*idx; saturated fields read as all nines
  always_comb begin
    digit_raw = bcd_q[{~idx_q, 2'b00} +: 4];
    if (!valid_q) begin
      dig.DIGIT_OUT = 4'd0;
    end else if (ovf_q) begin
      dig.DIGIT_OUT = 4'd9;
    end else begin
      dig.DIGIT_OUT = digit_raw;
    end
  end

  // Remaining stream qualifiers and status straight from registers
  always_comb begin
    dig.DIGIT_IDX   = idx_q;
    dig.FIELD       = field_q;
    dig.DIGIT_VALID = valid_q;
    dig.OVF         = ovf_q;
    dig.LAST        = valid_q && (idx_q == 3'd7) && (field_q == 3'd4);
    BUSY            = busy_q;
    DONE            = done_q;
  end

endmodule

// File: tb/tb_meas_bcd_streamer.sv
// Directed bench for meas_bcd_streamer: full readouts, saturation boundaries,
// backpressure, snapshot isolation, ignored START, and resets mid-readout.
module tb_meas_bcd_streamer;

  logic        CLK;
  logic        RSTB;
  logic        START;
  logic [31:0] max_vol, min_vol, mean_vol, Vp2p_vol_t;
  logic [23:0] frequency;
  logic        BUSY, DONE;

  meas_bcd_streamer_if dif ();

  meas_bcd_streamer dut (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .START      (START),
    .max_vol    (max_vol),
    .min_vol    (min_vol),
    .mean_vol   (mean_vol),
    .Vp2p_vol_t (Vp2p_vol_t),
    .frequency  (frequency),
    .dig        (dif),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  int vecs  = 0;
  int fails = 0;

  logic [31:0] exp_bcd [5];
  logic        exp_ovf [5];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200us;
    $display("FAIL watchdog: observed no end, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},  32'(dif.DIGIT_OUT),   32'd0);
    chk({tag, "_idx"},   32'(dif.DIGIT_IDX),   32'd0);
    chk({tag, "_field"}, 32'(dif.FIELD),       32'd0);
    chk({tag, "_valid"}, 32'(dif.DIGIT_VALID), 32'd0);
    chk({tag, "_last"},  32'(dif.LAST),        32'd0);
    chk({tag, "_ovf"},   32'(dif.OVF),         32'd0);
    chk({tag, "_busy"},  32'(BUSY),            32'd0);
    chk({tag, "_done"},  32'(DONE),            32'd0);
  endtask

  task automatic set_nominal();
    max_vol = 32'd1012; min_vol = 32'd1000; mean_vol = 32'd1006;
    Vp2p_vol_t = 32'd12; frequency = 24'd2500;
    exp_bcd[0] = 32'h00001012; exp_ovf[0] = 1'b0;
    exp_bcd[1] = 32'h00001000; exp_ovf[1] = 1'b0;
    exp_bcd[2] = 32'h00001006; exp_ovf[2] = 1'b0;
    exp_bcd[3] = 32'h00000012; exp_ovf[3] = 1'b0;
    exp_bcd[4] = 32'h00002500; exp_ovf[4] = 1'b0;
  endtask

  // One START pulse and a complete checked readout of all five fields
  task automatic readout(input bit perturb, input int stall_field, input int total_exp);
    int total;
    int w;
    logic [3:0] ed;
    START = 1'b1;
    tick();
    START = 1'b0;
    total = 0;
    chk("busy_after_start", 32'(BUSY), 32'd1);
    chk("valid_after_start", 32'(dif.DIGIT_VALID), 32'd0);
    for (int f = 0; f < 5; f++) begin
      w = 0;
      while (!dif.DIGIT_VALID && w < 40) begin
        if (perturb && f == 0 && w == 9) begin
          max_vol = 32'd5555; min_vol = 32'd4444; mean_vol = 32'd3333;
          Vp2p_vol_t = 32'd2222; frequency = 24'd1111;
        end
        if (perturb && f == 1 && w == 9) START = 1'b1;
        tick();
        START = 1'b0;
        w++;
        total++;
      end
      chk($sformatf("conv_latency_f%0d", f), 32'(w), 32'd32);
      for (int i = 0; i < 8; i++) begin
        ed = exp_ovf[f] ? 4'd9 : exp_bcd[f][(31 - 4*i) -: 4];
        chk($sformatf("digit_f%0d_i%0d", f, i), 32'(dif.DIGIT_OUT), 32'(ed));
        chk($sformatf("idx_f%0d_i%0d", f, i), 32'(dif.DIGIT_IDX), 32'(i));
        chk($sformatf("field_f%0d_i%0d", f, i), 32'(dif.FIELD), 32'(f));
        chk($sformatf("ovf_f%0d_i%0d", f, i), 32'(dif.OVF), 32'(exp_ovf[f]));
        chk($sformatf("valid_f%0d_i%0d", f, i), 32'(dif.DIGIT_VALID), 32'd1);
        chk($sformatf("last_f%0d_i%0d", f, i), 32'(dif.LAST), 32'(f == 4 && i == 7));
        if (f == stall_field && i == 3) begin
          dif.DIGIT_READY = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            total++;
            chk($sformatf("stall%0d_digit", s), 32'(dif.DIGIT_OUT), 32'(ed));
            chk($sformatf("stall%0d_idx", s), 32'(dif.DIGIT_IDX), 32'd3);
            chk($sformatf("stall%0d_field", s), 32'(dif.FIELD), 32'(f));
            chk($sformatf("stall%0d_valid", s), 32'(dif.DIGIT_VALID), 32'd1);
          end
          dif.DIGIT_READY = 1'b1;
        end
        tick();
        total++;
      end
    end
    chk("total_cycles", 32'(total), 32'(total_exp));
    chk("done_pulse", 32'(DONE), 32'd1);
    chk("busy_end", 32'(BUSY), 32'd0);
    chk("last_with_done", 32'(dif.LAST), 32'd0);
    chk("valid_end", 32'(dif.DIGIT_VALID), 32'd0);
    tick();
    chk("done_one_cycle", 32'(DONE), 32'd0);
  endtask

  initial begin
    RSTB = 1'b1; START = 1'b0; dif.DIGIT_READY = 1'b1;
    max_vol = '0; min_vol = '0; mean_vol = '0; Vp2p_vol_t = '0; frequency = '0;
    tick();
    tick();
    chk_all_zero("reset");
    RSTB = 1'b0;
    tick();

    // Nominal readout with snapshot isolation, ignored START and backpressure
    set_nominal();
    readout(1'b1, 2, 205);
    tick();
    chk("idle_after_ignored_start", 32'(BUSY), 32'd0);

    // Saturation boundaries
    max_vol = 32'hFFFF_FFFF; min_vol = 32'd99_999_999; mean_vol = 32'd100_000_000;
    Vp2p_vol_t = 32'd5; frequency = 24'hFF_FFFF;
    exp_bcd[0] = 32'h99999999; exp_ovf[0] = 1'b1;
    exp_bcd[1] = 32'h99999999; exp_ovf[1] = 1'b0;
    exp_bcd[2] = 32'h99999999; exp_ovf[2] = 1'b1;
    exp_bcd[3] = 32'h00000005; exp_ovf[3] = 1'b0;
    exp_bcd[4] = 32'h16777215; exp_ovf[4] = 1'b0;
    readout(1'b0, -1, 200);

    // Reset during conversion
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (19) tick();
    chk("conv_busy_pre_reset", 32'(BUSY), 32'd1);
    RSTB = 1'b1;
    tick();
    chk_all_zero("rst_conv");
    RSTB = 1'b0;
    tick();
    chk("rst_conv_stays_idle", 32'(BUSY), 32'd0);

    // Reset during a stalled emit of a saturated field
    dif.DIGIT_READY = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (35) tick();
    chk("emit_valid_pre_reset", 32'(dif.DIGIT_VALID), 32'd1);
    chk("emit_ovf_pre_reset", 32'(dif.OVF), 32'd1);
    chk("emit_digit_pre_reset", 32'(dif.DIGIT_OUT), 32'd9);
    RSTB = 1'b1;
    tick();
    chk_all_zero("rst_emit");
    RSTB = 1'b0;
    dif.DIGIT_READY = 1'b1;
    tick();

    // Fresh readout after the resets
    set_nominal();
    readout(1'b0, -1, 200);

    // START and reset on the same edge
    START = 1'b1; RSTB = 1'b1;
    tick();
    START = 1'b0; RSTB = 1'b0;
    chk("start_rst_busy", 32'(BUSY), 32'd0);
    repeat (3) tick();
    chk("start_rst_busy_later", 32'(BUSY), 32'd0);
    chk("start_rst_valid_later", 32'(dif.DIGIT_VALID), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
